// File: rtl/computie_bus_initiator_if.sv
// Computie initiator port bundle.
// The local request/response handshake and the multiplexed bus pins are carried together.
// master: the bus initiator's view. slave: the requester/target environment's view.
interface computie_bus_initiator_if #(
  parameter int unsigned BITWIDTH = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [BITWIDTH-1:0] req_addr;
  logic [BITWIDTH-1:0] req_wdata;
  logic                resp_valid;
  logic [BITWIDTH-1:0] resp_rdata;
  logic                resp_error;
  logic                cb_addr_strobe;
  logic                cb_data_strobe;
  logic                cb_read_write;
  logic                cb_data_ack;
  logic                cb_demux_oe;
  logic [BITWIDTH-1:0] cb_to_bus;
  logic [BITWIDTH-1:0] cb_from_bus;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, cb_data_ack, cb_from_bus,
    output req_ready, resp_valid, resp_rdata, resp_error,
           cb_addr_strobe, cb_data_strobe, cb_read_write, cb_demux_oe, cb_to_bus
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, cb_data_ack, cb_from_bus,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           cb_addr_strobe, cb_data_strobe, cb_read_write, cb_demux_oe, cb_to_bus
  );
endinterface

// File: rtl/computie_bus_initiator.sv
// Computie bus initiator: runs one address/data strobe cycle per accepted local request.
// Optional feature: define COMPUTIE_BUS_TIMEOUT_EN to end an unacknowledged data phase
// after TIMEOUT_CYCLES with resp_error set; otherwise DATA waits for ack indefinitely.
module computie_bus_initiator #(
  parameter int unsigned BITWIDTH        = 32,
  parameter int unsigned ADDR_CYCLES     = 4,
  parameter int unsigned RECOVERY_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                      comm_clock,
  input  logic                      cb_reset,
  computie_bus_initiator_if.master  bus
);

  localparam int unsigned CNT_MAX_AR = (ADDR_CYCLES > RECOVERY_CYCLES) ? ADDR_CYCLES : RECOVERY_CYCLES;
  localparam int unsigned CNT_MAX    = (CNT_MAX_AR > TIMEOUT_CYCLES) ? CNT_MAX_AR : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_END,
    ST_RECOVER
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [BITWIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;
  logic                as_q, as_d;
  logic                ds_q, ds_d;
  logic                rw_q, rw_d;
  logic                oe_q, oe_d;
  logic [BITWIDTH-1:0] to_bus_q, to_bus_d;
  logic                write_q, write_d;
  logic [BITWIDTH-1:0] wdata_q, wdata_d;
  logic [BITWIDTH-1:0] rdata_q, rdata_d;
  logic                ack_meta_q, ack_sync_q;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
  logic                timeout_q, timeout_d;
`endif

  // Two-flop synchronizer for the asynchronous active-low acknowledge
  always_ff @(posedge comm_clock or negedge cb_reset) begin
    if (!cb_reset) begin
      ack_meta_q <= 1'b1;
      ack_sync_q <= 1'b1;
    end else begin
      ack_meta_q <= bus.cb_data_ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  // State, counter and registered bus/response outputs
  always_ff @(posedge comm_clock or negedge cb_reset) begin
    if (!cb_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      as_q         <= 1'b1;
      ds_q         <= 1'b1;
      rw_q         <= 1'b1;
      oe_q         <= 1'b0;
      to_bus_q     <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      as_q         <= as_d;
      ds_q         <= ds_d;
      rw_q         <= rw_d;
      oe_q         <= oe_d;
      to_bus_q     <= to_bus_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  // Next-state and next-output logic for one bus cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q != CNT_W'(CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    as_d         = as_q;
    ds_d         = ds_q;
    rw_d         = rw_q;
    oe_d         = oe_q;
    to_bus_d     = to_bus_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
    timeout_d    = timeout_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          write_d     = bus.req_write;
          wdata_d     = bus.req_wdata;
          to_bus_d    = bus.req_addr;
          oe_d        = 1'b1;
          rw_d        = !bus.req_write;
          as_d        = 1'b0;
          state_d     = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (cnt_q == CNT_W'(ADDR_CYCLES - 1)) begin
          ds_d = 1'b0;
          if (write_q) begin
            to_bus_d = wdata_q;
            oe_d     = 1'b1;
          end else begin
            oe_d     = 1'b0;
          end
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (!ack_sync_q) begin
          rdata_d = write_q ? '0 : bus.cb_from_bus;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = ST_END;
        end
`ifdef COMPUTIE_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_END;
        end
`endif
      end

      ST_END: begin
        as_d         = 1'b1;
        ds_d         = 1'b1;
        oe_d         = 1'b0;
        rw_d         = 1'b1;
        resp_valid_d = 1'b1;
        resp_rdata_d = rdata_q;
`ifdef COMPUTIE_BUS_TIMEOUT_EN
        resp_error_d = timeout_q;
`else
        resp_error_d = 1'b0;
`endif
        state_d      = ST_RECOVER;
      end

      ST_RECOVER: begin
        // The target must have released ack before the bus is offered again
        if ((cnt_q >= CNT_W'(RECOVERY_CYCLES - 1)) && ack_sync_q) begin
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.cb_addr_strobe = as_q;
  assign bus.cb_data_strobe = ds_q;
  assign bus.cb_read_write  = rw_q;
  assign bus.cb_demux_oe    = oe_q;
  assign bus.cb_to_bus      = to_bus_q;

endmodule

// File: doc/computie_bus_initiator.md
# computie_bus_initiator

Bus master that runs one Computie bus cycle per local request. It drives the multiplexed address/data lines, the strobes and read/write, waits for the target's acknowledge, and returns read data or an error to the local requester. It sits directly upstream of `computie_bus_receiver` on the shared bus and generates the address-phase/data-phase sequence that the receiver decodes.

## Interface

- `BITWIDTH`, 32, width of address and data.
- `ADDR_CYCLES`, 4, `comm_clock` cycles address is held with AS low before DS falls (≥1).
- `RECOVERY_CYCLES`, 4, minimum cycles both strobes stay high between cycles (≥1).
- `TIMEOUT_CYCLES`, 255, cycles DS may stay low without acknowledge (used only with the timeout feature).

Ports:

- `comm_clock` in 1: sole clock.
- `cb_reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in BITWIDTH: address.
- `req_wdata` in BITWIDTH: write data.
- `resp_valid` out 1: one-cycle pulse on completion.
- `resp_rdata` out BITWIDTH: read data, valid with `resp_valid`.
- `resp_error` out 1: timeout flag, valid with `resp_valid`.
- `cb_addr_strobe` out 1: active-low AS.
- `cb_data_strobe` out 1: active-low DS.
- `cb_read_write` out 1: 1 = read, 0 = write.
- `cb_data_ack` in 1: active-low acknowledge from target, asynchronous.
- `cb_demux_oe` out 1: 1 = drive `cb_to_bus` onto the bus.
- `cb_to_bus` out BITWIDTH: address or write data.
- `cb_from_bus` in BITWIDTH: bus value for reads.

## Operation

- Reset values: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, AS=1, DS=1, `cb_read_write`=1, `cb_demux_oe`=0, `cb_to_bus`=0. State is IDLE.
- `cb_data_ack` passes through a 2-flop synchronizer before use.
- States:
  - IDLE: `req_ready`=1. On handshake, latch addr/wdata/write, drive `cb_to_bus`=addr, `cb_demux_oe`=1, `cb_read_write`=!write, AS=0. Go to ADDR.
  - ADDR: counts ADDR_CYCLES. Then DS=0. For writes, `cb_to_bus`=wdata and oe stays 1. For reads, oe=0. Go to DATA.
  - DATA: wait for synced ack=0. On ack, capture `cb_from_bus` into `resp_rdata` for reads, or 0 for writes, then go to END.
  - END: AS=1, DS=1, oe=0, `resp_valid`=1 for one cycle. Go to RECOVER.
  - RECOVER: `cb_read_write`=1. Stay at least RECOVERY_CYCLES and until synced ack=1. Then go to IDLE.
- `req_ready` is 0 in every state except IDLE. Requests arriving then are held off; none are dropped.
- Back-to-back requests: the minimum cycle period is 1 + ADDR_CYCLES + 2 (sync) + 1 + RECOVERY_CYCLES.
- Counters are sized as `$clog2(max param + 1)`. They reset to 0 on each state entry and do not wrap.
- Reset mid-cycle returns to IDLE immediately with outputs at reset values, releasing the bus within the reset assertion.

## Timing

- From handshake, AS falls at the next edge.
- DS falls ADDR_CYCLES edges after AS.
- Ack seen at the pins takes 2–3 edges to be detected. Read data is sampled on the edge that detects it.
- `resp_valid` and strobe deassertion occur on the same edge, one after detection.
- `resp_rdata`/`resp_error` hold until the next `resp_valid`.
- Ack already low at DS fall is accepted. This is a legal fast target.

## Configuration

- `COMPUTIE_BUS_TIMEOUT_EN` defined:
  - DATA counts cycles. At TIMEOUT_CYCLES without ack it goes to END with `resp_error`=1 and `resp_rdata`=0.
  - RECOVER still waits for ack high.
- Not defined: no counter, and DATA waits indefinitely. `resp_error` is tied to 0.

## Test plan

- Write 32'h2020FFFF ← 32'hAAAAAAAA, ack 3 cycles after DS:
  - AS low with bus=2020FFFF and rw=0.
  - DS low after 4 cycles with bus=AAAAAAAA.
  - `resp_valid` with error=0.
- Read 32'h12345678, target drives 32'h55555555 and acks:
  - oe=0 during DATA.
  - `resp_rdata`=55555555, rw=1.
- Two back-to-back writes with `req_valid` held high:
  - Second AS fall ≥ RECOVERY_CYCLES after first AS rise.
  - `req_ready` is low throughout the first cycle.
- Ack held low after completion for 10 cycles: IDLE is not re-entered, and no new AS, until ack rises.
- With `COMPUTIE_BUS_TIMEOUT_EN`, read with no ack:
  - `resp_valid` with error=1 and rdata=0 after 255 DS-low cycles.
  - The bus is released.
- `cb_reset` pulsed low during DATA of a write: AS, DS and oe return to 1/1/0 asynchronously, with no `resp_valid`. The next request completes normally.
